mac_pack: RTL and testbench
===========================

# mac_pack

Byte-to-word packer for the MAC datapath: collects 8-bit bytes one per handshake and emits 128-bit words for loading into the MAC byte buffer. Byte k of a word (k = 0 first received) lands in out_data[127-8k : 120-8k], so a byte buffer loaded with out_data returns byte k at read index k. A partial word can be closed early with `flush` and is zero-padded. One accumulation register and one output register let filling continue while a finished word waits for the consumer.

## Interface
- No parameters; word width is fixed at 128 bits (16 bytes).
- `clk`  in  1  rising-edge clock; one clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  producer has a byte on `in_data`.
- `in_data`  in  8  input byte.
- `in_ready`  out  1  block accepts a byte this cycle; transfer = `in_valid & in_ready`.
- `flush`  in  1  close the current partial word; single-cycle level, sampled each edge.
- `out_valid`  out  1  `out_data`/`out_count` hold a finished word.
- `out_data`  out  128  packed word; byte 0 in [127:120].
- `out_count`  out  5  number of real bytes in `out_data` (1..16); 0 when `out_valid`=0.
- `out_ready`  in  1  consumer takes the word; transfer = `out_valid & out_ready`.

## Operation
- State: `idx` (5 bits, 0..16) is the byte count in `acc` (128 bits). The FSM has two states, FILL and HOLD.
- Reset (async, `rst_n`=0): state=FILL, `idx`=0, `acc`=0, `out_data`=0, `out_count`=0, `out_valid`=0. `in_ready` is combinational (state==FILL), so it reads 1 while in reset.
- FILL behaviour:
  - `in_ready`=1.
  - On an accepted byte: `acc[127-8*idx -: 8]` <= `in_data`, and `idx` <= `idx`+1.
  - Go to HOLD if the accepted byte makes `idx`=16.
  - Go to HOLD if `flush`=1 and the resulting count (including a byte accepted the same cycle) is greater than 0.
  - `flush`=1 with `idx`=0 and no byte accepted: ignored, no word emitted.
- HOLD behaviour:
  - `in_ready`=0.
  - When the output slot is free (`out_valid`=0, or `out_ready`=1 this cycle), load the output: `out_data` <= `acc`, `out_count` <= `idx`, `out_valid` <= 1.
  - In the same cycle, clear `acc`<=0 and `idx`<=0, and go to FILL.
  - Clearing `acc` guarantees zero padding for bytes ≥ `out_count`.
- Output register:
  - `out_valid` falls after `out_valid & out_ready` unless a HOLD load happens in the same cycle; a load wins, so back-to-back words have no bubble on the output side.
  - While `out_valid`=1 and `out_ready`=0, `out_data`/`out_count` are stable.
  - When `out_valid` falls, `out_count` <= 0 and `out_data` keeps its last value.
- `flush` in HOLD is ignored, since the word is already closed.
- No overflow is possible: `in_ready`=0 whenever `idx`=16.

## Timing
- Latency: the last byte (or flush) is accepted at edge N, giving HOLD after N. If the slot is free, `out_valid`=1 after edge N+1.
- Throughput: a full word takes 16 accept cycles plus 1 HOLD cycle, i.e. 17 cycles per word under continuous input and `out_ready`=1.
- Backpressure:
  - With `out_valid`=1 and `out_ready`=0, a second closed word waits in HOLD and `in_ready` stays 0.
  - The first cycle `out_ready`=1 both consumes the old word and loads the new one, so `out_valid` stays 1.
- Reset mid-operation: all state is cleared immediately (asynchronous). A partial or pending word is discarded and never emitted.
- Handshake outputs are registered except `in_ready` (decoded from state only, with no path from `in_valid`/`out_ready`).

## Test plan
- Full word: after reset, send 0x00..0x0F with `out_ready`=1.
  - Required: `out_data`=128'h000102030405060708090A0B0C0D0E0F and `out_count`=16.
  - `out_valid` rises 1 cycle after the 16th byte and stays high 1 cycle.
  - `in_ready`=0 for exactly 1 cycle.
- Flush partial: send 0xAA, 0xBB, 0xCC, then pulse `flush` together with byte 0xDD.
  - Required: `out_data`=128'hAABBCCDD followed by 24 zero nibbles, and `out_count`=4.
- Empty flush: pulse `flush` with no bytes buffered.
  - Required: `out_valid` stays 0 and `in_ready` stays 1.
- Backpressure: hold `out_ready`=0 and stream 32 bytes.
  - Required: word 1 stays stable on the output and word 2 waits in HOLD with `in_ready`=0.
  - Raise `out_ready` for 2 cycles. Required: word 1 then word 2 are consumed with no `out_valid` gap, and filling resumes.
- Reset mid-word: send 7 bytes, assert `rst_n`=0 mid-cycle, then release.
  - Required: `out_valid`=0, `out_count`=0 and `in_ready`=1 immediately.
  - The next 16 bytes 0x10..0x1F produce exactly one word with byte 0 = 0x10.
- Random stream: send 1000 bytes with random `in_valid`/`out_ready`/`flush`.
  - Required: the scoreboard matches every byte and its position.
  - Padding is zero and `out_count` is correct; no byte is lost or duplicated.

Source files
------------

// File: rtl/mac_pack.sv
// mac_pack: packs 8-bit bytes into 128-bit words, byte 0 in [127:120]; flush closes a partial word zero-padded.
// Word closes at the accepting edge, out_valid rises one edge later; in_ready drops while a closed word waits.
module mac_pack (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  output logic         in_ready,
  input  logic         flush,
  output logic         out_valid,
  output logic [127:0] out_data,
  output logic [4:0]   out_count,
  input  logic         out_ready
);

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [4:0]     idx_q, idx_d;
  logic [127:0]   acc_q, acc_d;
  logic [127:0]   out_data_q, out_data_d;
  logic [4:0]     out_count_q, out_count_d;
  logic           out_valid_q, out_valid_d;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_valid_d = out_valid_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_count_d = 5'd0;
    end

    if (state_q == FILL) begin
      // acc slots beyond idx are always zero, so OR-ing the byte in is safe
      if (in_valid) begin
        acc_d = acc_q | ({in_data, 120'd0} >> {idx_q, 3'b000});
        idx_d = idx_q + 5'd1;
      end
      if (idx_d == 5'd16 || (flush && idx_d != 5'd0)) begin
        state_d = HOLD;
      end
    end else begin
      // a load overrides the consume above, so back-to-back words have no bubble
      if (!out_valid_q || out_ready) begin
        out_data_d  = acc_q;
        out_count_d = idx_q;
        out_valid_d = 1'b1;
        acc_d       = '0;
        idx_d       = '0;
        state_d     = FILL;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      idx_q       <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == FILL);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_mac_pack.sv
// Bench for mac_pack: directed cases plus a random stream checked against a byte-packing scoreboard.
module tb_mac_pack;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_ready;
  logic         flush;
  logic         out_valid;
  logic [127:0] out_data;
  logic [4:0]   out_count;
  logic         out_ready;

  mac_pack dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_count (out_count),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // scoreboard: model packs accepted bytes; words are pushed when closed
  logic [127:0] exp_data_q[$];
  int           exp_cnt_q[$];
  logic [127:0] mbuf;
  int           mcnt   = 0;
  int           nbytes = 0;
  int           npops  = 0;

  // transfers seen here happen at the next rising edge
  always @(negedge clk) begin
    if (!rst_n) begin
      mbuf = '0;
      mcnt = 0;
      exp_data_q.delete();
      exp_cnt_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_data_q.size() == 0) begin
          chk("sb_unexpected_word", 128'(out_count), 128'(0));
        end else begin
          chk("sb_data", out_data, exp_data_q.pop_front());
          chk("sb_count", 128'(out_count), 128'(exp_cnt_q.pop_front()));
          npops++;
        end
      end
      if (in_valid && in_ready) begin
        mbuf[127-8*mcnt -: 8] = in_data;
        mcnt++;
        nbytes++;
      end
      if (mcnt == 16 || (flush && mcnt != 0)) begin
        exp_data_q.push_back(mbuf);
        exp_cnt_q.push_back(mcnt);
        mbuf = '0;
        mcnt = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic fl);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    flush    = fl;
    while (!in_ready && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) chk("send_timeout", 128'(1), 128'(0));
    step();
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  initial begin
    logic [127:0] w1;
    logic [127:0] w2;
    int           p0;
    int           cyc;
    int           target;

    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; flush = 1'b0; out_ready = 1'b1;
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_count", 128'(out_count), 128'(0));
    chk("rst_out_data", out_data, 128'd0);
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    step(); step();
    rst_n = 1'b1;
    step();

    // full word
    for (int i = 0; i < 16; i++) send(8'(i), 1'b0);
    chk("full_in_ready_hold", 128'(in_ready), 128'(0));
    chk("full_valid_early", 128'(out_valid), 128'(0));
    step();
    chk("full_valid", 128'(out_valid), 128'(1));
    chk("full_data", out_data, 128'h000102030405060708090A0B0C0D0E0F);
    chk("full_count", 128'(out_count), 128'(16));
    chk("full_in_ready_back", 128'(in_ready), 128'(1));
    step();
    chk("full_valid_fall", 128'(out_valid), 128'(0));
    chk("full_count_fall", 128'(out_count), 128'(0));

    // flush with a byte on the same edge
    send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b0); send(8'hDD, 1'b1);
    chk("flush_in_ready", 128'(in_ready), 128'(0));
    step();
    chk("flush_valid", 128'(out_valid), 128'(1));
    chk("flush_data", out_data, {32'hAABBCCDD, 96'd0});
    chk("flush_count", 128'(out_count), 128'(4));
    step();

    // flush with nothing buffered
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("eflush_valid", 128'(out_valid), 128'(0));
    chk("eflush_in_ready", 128'(in_ready), 128'(1));
    step();
    chk("eflush_valid2", 128'(out_valid), 128'(0));

    // backpressure: two words, consumer stalled
    out_ready = 1'b0;
    w1 = '0; w2 = '0;
    for (int i = 0; i < 16; i++) w1[127-8*i -: 8] = 8'(8'h20 + i);
    for (int i = 0; i < 16; i++) w2[127-8*i -: 8] = 8'(8'h30 + i);
    for (int i = 0; i < 32; i++) send(8'(8'h20 + i), 1'b0);
    step(); step(); step();
    chk("bp_in_ready", 128'(in_ready), 128'(0));
    chk("bp_valid", 128'(out_valid), 128'(1));
    chk("bp_word1_stable", out_data, w1);
    chk("bp_count1", 128'(out_count), 128'(16));
    out_ready = 1'b1;
    step();
    chk("bp_no_gap", 128'(out_valid), 128'(1));
    chk("bp_word2", out_data, w2);
    step();
    chk("bp_drained", 128'(out_valid), 128'(0));
    chk("bp_resume", 128'(in_ready), 128'(1));

    // reset in the middle of a word
    for (int i = 0; i < 7; i++) send(8'(8'hE0 + i), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_valid", 128'(out_valid), 128'(0));
    chk("mrst_count", 128'(out_count), 128'(0));
    chk("mrst_in_ready", 128'(in_ready), 128'(1));
    step();
    rst_n = 1'b1;
    step();
    p0 = npops;
    for (int i = 0; i < 16; i++) send(8'(8'h10 + i), 1'b0);
    step();
    chk("mrst_byte0", 128'(out_data[127:120]), 128'(8'h10));
    chk("mrst_count16", 128'(out_count), 128'(16));
    step(); step();
    chk("mrst_one_word", 128'(npops - p0), 128'(1));

    // random stream of 1000 bytes
    target = nbytes + 1000;
    cyc = 0;
    while (nbytes < target && cyc < 20000) begin
      in_valid  = ($urandom_range(3) != 0);
      in_data   = 8'($urandom);
      flush     = ($urandom_range(15) == 0);
      out_ready = ($urandom_range(3) != 0);
      step();
      cyc++;
    end
    if (cyc >= 20000) chk("rand_timeout", 128'(1), 128'(0));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    flush     = 1'b1;
    step(); step();
    flush = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("rand_sb_empty", 128'(exp_data_q.size()), 128'(0));
    chk("rand_idle_valid", 128'(out_valid), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
